// File: rtl/ram_link_responder.sv
// rtl/ram_link_responder.sv - memory-side responder of the 16-bit RAM link
module ram_link_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] READ_FILL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] link_in,
  input  logic        link_valid,
  input  logic        link_we,
  output logic [15:0] link_out,
  output logic        link_oe,
  output logic        link_ack
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_WDATA_HI,
    S_WDATA_LO,
    S_COMMIT,
    S_TURN,
    S_RDATA_HI,
    S_RDATA_LO
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] addr_hi;
  logic [15:0] addr_lo;
  logic        we_q;
  logic [15:0] data_hi;
  logic [15:0] data_lo;
  logic [31:0] rdata;

  logic [31:0]          addr_full;
  logic [ADDR_BITS-1:0] index;

  logic [31:0] mem [DEPTH];

  // Byte offset bits drop out with the shift; bits above the array depth
  // are discarded by the truncating cast, so addresses alias modulo depth.
  assign addr_full = {addr_hi, addr_lo};
  assign index     = ADDR_BITS'(addr_full >> 2);

  // State register; reset wins over everything, including a half-done write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accepting states advance only on link_valid, the rest are timed.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (link_valid) state_nxt = S_ADDR_LO;
      S_ADDR_LO:  if (link_valid) state_nxt = we_q ? S_WDATA_HI : S_TURN;
      S_WDATA_HI: if (link_valid) state_nxt = S_WDATA_LO;
      S_WDATA_LO: if (link_valid) state_nxt = S_COMMIT;
      S_COMMIT:   state_nxt = S_IDLE;
      S_TURN:     state_nxt = S_RDATA_HI;
      S_RDATA_HI: state_nxt = S_RDATA_LO;
      S_RDATA_LO: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Holding registers capture each accepted beat; command type only on beat A.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi <= 16'h0000;
      addr_lo <= 16'h0000;
      we_q    <= 1'b0;
      data_hi <= 16'h0000;
      data_lo <= 16'h0000;
    end else if (link_valid) begin
      case (state)
        S_IDLE: begin
          addr_hi <= link_in;
          we_q    <= link_we;
        end
        S_ADDR_LO:  addr_lo <= link_in;
        S_WDATA_HI: data_hi <= link_in;
        S_WDATA_LO: data_lo <= link_in;
        default: ;
      endcase
    end
  end

  // Array write happens only in COMMIT, so a reset before that drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state == S_COMMIT) begin
      mem[index] <= {data_hi, data_lo};
    end
  end

  // Registered array read during the turnaround cycle feeds both read beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (state == S_TURN) begin
      rdata <= mem[index];
    end
  end

  // Outputs decode from state alone; the bus is owned only for the two data beats.
  always_comb begin
    link_out = READ_FILL[15:0];
    link_oe  = 1'b0;
    link_ack = 1'b0;
    case (state)
      S_COMMIT: link_ack = 1'b1;
      S_RDATA_HI: begin
        link_oe  = 1'b1;
        link_out = rdata[31:16];
      end
      S_RDATA_LO: begin
        link_oe  = 1'b1;
        link_out = rdata[15:0];
        link_ack = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_link_responder.md
Name: ram_link_responder

Overview:
Memory-side end of the 16-bit RAM link. It receives word-addressed read and write commands from the CPU-side RAM controller as 16-bit beats. It stores 32-bit words in an internal array and returns read data as two 16-bit beats. The top level folds link_out/link_oe/link_in into the bidirectional ram_link bus as follows: ram_link driven with link_out when link_oe=1, else high-Z.

Parameters:
ADDR_BITS, 10, word-index width; array depth = 2**ADDR_BITS 32-bit words
READ_FILL, 32'h0000_0000, value link_out shows when link_oe=0

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
link_in  input  16  command/address/write-data beat from initiator
link_valid  input  1  initiator beat strobe; link_in accepted only when 1 in an accepting state
link_we  input  1  command type, sampled with the first address beat only (1=write, 0=read)
link_out  output  16  read-data beat
link_oe  output  1  responder owns the bus (read-data beats only)
link_ack  output  1  one-cycle completion pulse

Behaviour:
- Reset values: state=IDLE, link_oe=0, link_ack=0, link_out=READ_FILL[15:0], address/data holding registers=0. The array is not cleared by reset.
- Reset mid-command (any state) returns to IDLE on the next edge. A partial write never commits. rst has priority over every other input.
- Command format:
  - Beat A: addr[31:16]. Beat B: addr[15:0].
  - Write only: beat C = data[31:16], beat D = data[15:0].
- Address rules: addr[1:0] ignored; index = addr[ADDR_BITS+1:2]; upper bits ignored, so addresses alias modulo depth.
- States:
  - IDLE: link_valid=1 -> latch addr_hi and link_we, go to ADDR_LO.
  - ADDR_LO: link_valid=1 -> latch addr_lo; go to WDATA_HI if write, else TURN.
  - WDATA_HI: link_valid=1 -> latch data_hi, go to WDATA_LO.
  - WDATA_LO: link_valid=1 -> latch data_lo, go to COMMIT.
  - COMMIT: array[index] <= {data_hi,data_lo}; link_ack=1; go to IDLE.
  - TURN: link_oe=0 (bus turnaround); registered array read into rdata; go to RDATA_HI.
  - RDATA_HI: link_oe=1, link_out=rdata[31:16]; go to RDATA_LO.
  - RDATA_LO: link_oe=1, link_out=rdata[15:0], link_ack=1; go to IDLE.
- Stall: in accepting states (IDLE, ADDR_LO, WDATA_*), link_valid=0 holds the state indefinitely with no timeout.
- link_valid and link_in are ignored in COMMIT, TURN, RDATA_HI and RDATA_LO. The initiator must not drive the bus during these states; this is not checked.
- Latency: for a write, link_ack is high the cycle after beat D is accepted. For a read, with beat B accepted at edge N: hi beat visible in cycle N+2, lo beat plus ack in cycle N+3.
- Back-to-back: a new beat A is accepted in the cycle after link_ack (first IDLE cycle). Ack-to-next-command gap is 0 cycles.
- link_oe is high only in RDATA_HI and RDATA_LO, and never in the same cycle the responder accepts a beat.
- link_ack is exactly one cycle wide; it is never high in two consecutive cycles.
- Read after write to the same index returns the new data, since the commit completes before the next command is accepted.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with link_valid=1 toggling -> link_oe=0, link_ack=0, link_out=16'h0000, FSM in IDLE; first command after release is accepted normally.
2. Write 0x0000_0010 <- 0xCAFE_BABE (beats 0000,0010,CAFE,BABE), then read 0x0000_0010 -> ack one cycle after beat D. Read: link_out=CAFE with oe=1 at N+2, BABE with oe=1 and ack=1 at N+3, oe=0 at N+4.
3. Stalls: same write with link_valid=0 for 3 cycles between each beat -> state holds, array unchanged until COMMIT, ack exactly one cycle after beat D; readback 0xCAFE_BABE.
4. Aliasing (ADDR_BITS=10): write 0x0000_1007 <- 0x1234_5678, read 0x0000_0004 -> returns 0x1234_5678.
5. Reset mid-operation: assert rst during TURN of a read -> oe=0, ack=0 next cycle. Reset after beat C of a write to 0x20 (old value 0xAAAA_5555) -> readback 0xAAAA_5555.
6. Back-to-back: read 0x10 immediately followed by write 0x14 <- 0x0BAD_F00D with beat A in the first cycle after ack -> both complete, read 0x14 returns 0x0BAD_F00D, no dropped beats.
